// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
//   Control-plane bundle between the datapath / hazard unit and pipeline_ctrl.
//
//   modport master : datapath side. Drives stall, hazard, redirect and halt
//                    requests, and observes PC plus per-register gating.
//   modport slave  : pipeline_ctrl. Consumes requests, drives PC and gating.
//
//   master -> slave : ext_stall, load_use_hz, redirect, redirect_pc, halt_dec
//   slave -> master : pc, stage_en, stage_bubble, stage_valid, halted, state
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
   parameter int PC_W = 9,
   parameter int NREG = 4
);
   logic            ext_stall;
   logic            load_use_hz;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            halt_dec;

   logic [PC_W-1:0] pc;
   logic [NREG-1:0] stage_en;
   logic [NREG-1:0] stage_bubble;
   logic [NREG-1:0] stage_valid;
   logic            halted;
   logic [1:0]      state;

   modport master (
      output ext_stall, load_use_hz, redirect, redirect_pc, halt_dec,
      input  pc, stage_en, stage_bubble, stage_valid, halted, state
   );

   modport slave (
      input  ext_stall, load_use_hz, redirect, redirect_pc, halt_dec,
      output pc, stage_en, stage_bubble, stage_valid, halted, state
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Control plane of an NREG-deep in-order pipeline. Owns the fetch PC, the
//   per-register valid bits and halt tags, and tells the datapath, per pipe
//   register, whether to capture this cycle and whether to capture a NOP.
//   A RUN / DRAIN / HALTED state machine lets a halt instruction retire
//   cleanly before the core freezes.
//
//   Cycle priority: ext_stall > redirect > load_use_hz > halt/drain > advance.
//
// Ports
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    pipeline_ctrl_if.slave
//            ext_stall, load_use_hz, redirect, redirect_pc, halt_dec (in)
//            pc, stage_en, stage_bubble, stage_valid, halted, state  (out)
//   cyc_cnt, ret_cnt, stall_cnt, flush_cnt  (out, 32 b, only with the
//            PIPE_PERF_CNT_EN macro defined; saturating event counters)
//
// Build option
//   PIPE_PERF_CNT_EN : define to add the performance counters.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int PC_W     = 9,
   parameter int NREG     = 4,   // legal 3..8
   parameter int EX_IDX   = 1,   // pipe register whose contents are in EX
   parameter int RESET_PC = 0
) (
   input logic            clk,
   input logic            reset,
   pipeline_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]    cyc_cnt,
   output logic [31:0]    ret_cnt,
   output logic [31:0]    stall_cnt,
   output logic [31:0]    flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

   state_t          state_q;
   logic            halted_q;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [NREG-1:0] valid_q, valid_d, valid_src;
   logic [NREG-1:1] hb_q, hb_d, hb_src;   // halt tags; reg 0's tag is halt_dec itself
   logic [NREG-1:0] en, bub;

   logic frozen, do_redirect, do_load_use, do_advance, do_halt;

   // --------------------------------------------------------------------------
   // Decide which single action wins this cycle.
   // --------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default before any branch; a path
   // that leaves a signal unassigned would infer a latch.
   always_comb begin
      frozen      = (state_q == ST_HALTED) || bus.ext_stall;
      do_redirect = !frozen && bus.redirect;
      do_load_use = !frozen && !bus.redirect && bus.load_use_hz;
      do_advance  = !frozen && !bus.redirect && !bus.load_use_hz;
      // A halt only counts when reg 0 really holds an instruction.
      do_halt     = do_advance && (state_q == ST_RUN) && bus.halt_dec && valid_q[0];
   end

   // --------------------------------------------------------------------------
   // Per-register capture enable / bubble strobes.
   // --------------------------------------------------------------------------
   always_comb begin
      en  = '0;
      bub = '0;
      for (int k = 0; k < NREG; k++) begin
         if (reset) begin
            bub[k] = 1'b1;
         end else if (do_redirect) begin
            // Everything at or younger than the branch is wrong-path.
            en[k]  = 1'b1;
            bub[k] = (k <= EX_IDX);
         end else if (do_load_use) begin
            // Younger regs and PC wait; one NOP is inserted behind the load.
            en[k]  = (k >= EX_IDX);
            bub[k] = (k == EX_IDX);
         end else if (do_advance) begin
            // During drain (and on the halt cycle itself) nothing new is fetched.
            en[k]  = 1'b1;
            bub[k] = (k == 0) && ((state_q == ST_DRAIN) || do_halt);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next valid bits, halt tags and PC.
   // --------------------------------------------------------------------------
   assign valid_src = {valid_q[NREG-2:0], 1'b1};
   assign hb_src    = {hb_q[NREG-2:1], do_halt};

   always_comb begin
      valid_d = valid_q;
      hb_d    = hb_q;
      for (int k = 0; k < NREG; k++) begin
         if (en[k]) valid_d[k] = valid_src[k] & ~bub[k];
      end
      for (int k = 1; k < NREG; k++) begin
         if (en[k]) hb_d[k] = hb_src[k] & ~bub[k];
      end

      pc_d = pc_q;
      if (do_redirect)
         pc_d = bus.redirect_pc;
      else if (do_advance && (state_q == ST_RUN) && !do_halt)
         pc_d = pc_q + PC_INC;   // wraps mod 2^PC_W
   end

   // --------------------------------------------------------------------------
   // State register and halt FSM.
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
         pc_q     <= PC_RST;
         valid_q  <= '0;
         hb_q     <= '0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         hb_q    <= hb_d;
         if (!frozen) begin
            if ((state_q == ST_DRAIN) && hb_q[NREG-1] && en[NREG-1]) begin
               state_q  <= ST_HALTED;
               halted_q <= 1'b1;
            end else if (do_halt) begin
               state_q <= ST_DRAIN;
            end else if ((state_q == ST_DRAIN) && do_redirect && (hb_d == '0)) begin
               // The halt was younger than the branch and got flushed.
               state_q <= ST_RUN;
            end
         end
      end
   end

   assign bus.pc           = pc_q;
   assign bus.stage_en     = en;
   assign bus.stage_bubble = bub;
   assign bus.stage_valid  = valid_q;
   assign bus.halted       = halted_q;
   assign bus.state        = state_q;

`ifdef PIPE_PERF_CNT_EN
   // --------------------------------------------------------------------------
   // Saturating performance counters.
   // --------------------------------------------------------------------------
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
      return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt   <= '0;
         ret_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         cyc_cnt   <= sat_inc(cyc_cnt, state_q != ST_HALTED);
         ret_cnt   <= sat_inc(ret_cnt, valid_q[NREG-1] && en[NREG-1]);
         stall_cnt <= sat_inc(stall_cnt, (state_q != ST_HALTED) && (bus.ext_stall || do_load_use));
         flush_cnt <= sat_inc(flush_cnt, do_redirect);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl. The reference model tracks which
//   fetch address sits in each pipe register (or a bubble) and whether it is
//   the halt instruction, and derives the expected strobes, PC, valid bits and
//   state from the priority rules. Directed scenarios pin the model with
//   hand-computed literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
   localparam int PC_W     = 9;
   localparam int NREG     = 4;
   localparam int EX_IDX   = 1;
   localparam int RESET_PC = 0;
   localparam int PC_MOD   = 1 << PC_W;

   logic clk = 1'b0;
   logic reset;

   pipeline_ctrl_if #(.PC_W(PC_W), .NREG(NREG)) bus ();

   pipeline_ctrl #(
      .PC_W(PC_W), .NREG(NREG), .EX_IDX(EX_IDX), .RESET_PC(RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: slot contents are fetch addresses, -1 is a bubble.
   // ---------------------------------------------------------------------------
   typedef enum {F_HOLD, F_BUBBLE, F_ADVANCE} fate_e;

   int m_slot [NREG];
   bit m_halt [NREG];
   int m_pc;
   int m_state;     // 0 RUN, 1 DRAIN, 2 HALTED
   bit halt_armed;
   int halt_pc;

   task automatic m_reset();
      for (int k = 0; k < NREG; k++) begin
         m_slot[k] = -1;
         m_halt[k] = 1'b0;
      end
      m_pc       = RESET_PC;
      m_state    = 0;
      halt_armed = 1'b0;
   endtask

   function automatic bit m_halt_now();
      return (m_state == 0) && !bus.ext_stall && !bus.redirect && !bus.load_use_hz
             && bus.halt_dec && (m_slot[0] >= 0);
   endfunction

   function automatic fate_e m_fate(input int k);
      if ((m_state == 2) || bus.ext_stall) return F_HOLD;
      if (bus.redirect) return (k <= EX_IDX) ? F_BUBBLE : F_ADVANCE;
      if (bus.load_use_hz)
         return (k < EX_IDX) ? F_HOLD : ((k == EX_IDX) ? F_BUBBLE : F_ADVANCE);
      if ((k == 0) && ((m_state == 1) || m_halt_now())) return F_BUBBLE;
      return F_ADVANCE;
   endfunction

   function automatic logic [NREG-1:0] m_valid();
      logic [NREG-1:0] v;
      for (int k = 0; k < NREG; k++) v[k] = (m_slot[k] >= 0);
      return v;
   endfunction

   task automatic check_regs();
      check("pc", bus.pc, m_pc);
      check("stage_valid", bus.stage_valid, m_valid());
      check("state", bus.state, m_state);
      check("halted", bus.halted, (m_state == 2));
   endtask

   // Drive one cycle's inputs; halt_dec reflects the instruction in reg 0.
   task automatic drive(input bit stall, input bit redir, input int rpc, input bit lu);
      bus.ext_stall   = stall;
      bus.redirect    = redir;
      bus.redirect_pc = PC_W'(rpc);
      bus.load_use_hz = lu;
      bus.halt_dec    = halt_armed && (m_slot[0] == halt_pc);
      #1;
   endtask

   // Check strobes, advance model and DUT one clock, check registered outputs.
   task automatic step();
      logic [NREG-1:0] e_en, e_bub;
      fate_e f [NREG];
      bit hnow, leaving, any_halt;
      for (int k = 0; k < NREG; k++) begin
         f[k]     = m_fate(k);
         e_en[k]  = (f[k] != F_HOLD);
         e_bub[k] = (f[k] == F_BUBBLE);
      end
      check("stage_en", bus.stage_en, e_en);
      check("stage_bubble", bus.stage_bubble, e_bub);

      hnow    = m_halt_now();
      leaving = m_halt[NREG-1] && (f[NREG-1] != F_HOLD);
      for (int k = NREG - 1; k >= 0; k--) begin
         case (f[k])
            F_BUBBLE: begin m_slot[k] = -1; m_halt[k] = 1'b0; end
            F_ADVANCE: begin
               if (k == 0) begin
                  m_slot[0] = m_pc;
                  m_halt[0] = 1'b0;
               end else begin
                  m_slot[k] = m_slot[k-1];
                  m_halt[k] = (k == 1) ? hnow : m_halt[k-1];
               end
            end
            default: ;
         endcase
      end
      any_halt = 1'b0;
      for (int k = 0; k < NREG; k++) any_halt |= m_halt[k];

      if (!((m_state == 2) || bus.ext_stall)) begin
         if (bus.redirect)
            m_pc = int'(bus.redirect_pc);
         else if (!bus.load_use_hz && (m_state == 0) && !hnow)
            m_pc = (m_pc + 4) % PC_MOD;

         if (leaving)                                   m_state = 2;
         else if (hnow)                                 m_state = 1;
         else if ((m_state == 1) && bus.redirect && !any_halt) m_state = 0;
      end

      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic apply_reset();
      drive($urandom % 2, $urandom % 2, 4 * ($urandom % 128), $urandom % 2);
      reset = 1'b1;
      #1;
      m_reset();
      check("reset_en", bus.stage_en, '0);
      check("reset_bubble", bus.stage_bubble, {NREG{1'b1}});
      check("reset_pc", bus.pc, RESET_PC);
      check("reset_valid", bus.stage_valid, '0);
      check("reset_state", bus.state, 0);
      check("reset_halted", bus.halted, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_regs();
   endtask

   logic [NREG-1:0] vtab [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

   initial begin
      int halted_age, armed_age;
      reset = 1'b1;
      bus.ext_stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
      bus.load_use_hz = 0; bus.halt_dec = 0;
      m_reset();
      apply_reset();

      // Free run: pc 4..16 and valid filling from reg 0.
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0);
         step();
         check("free_pc", bus.pc, 4 * (i + 1));
         check("free_valid", bus.stage_valid, vtab[i]);
      end

      // Load-use at pc=16.
      drive(0, 0, 0, 1);
      check("lu_bubble", bus.stage_bubble, 4'b0010);
      check("lu_en", bus.stage_en, 4'b1110);
      step();
      check("lu_pc_hold", bus.pc, 16);
      check("lu_valid", bus.stage_valid, 4'b1101);
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0); step(); end
      check("pc_24", bus.pc, 24);

      // Redirect held off by 3 stall cycles, taken on the 4th.
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 'h40, 0);
         check("stall_en", bus.stage_en, 0);
         step();
         check("stall_pc", bus.pc, 24);
      end
      drive(0, 1, 'h40, 0);
      check("redir_bubble", bus.stage_bubble, 4'b0011);
      step();
      check("redir_pc", bus.pc, 'h40);
      check("redir_valid_lo", bus.stage_valid[1:0], 0);
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0); step(); end
      check("refill_pc", bus.pc, 'h48);

      // Halt fetched at 0x48: DRAIN, pc frozen, halted after NREG cycles.
      halt_armed = 1'b1;
      halt_pc    = 'h48;
      drive(0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      check("halt_dec_seen", bus.halt_dec, 1);
      check("halt_bubble", bus.stage_bubble, 4'b0001);
      step();
      check("drain_state", bus.state, 1);
      check("drain_pc", bus.pc, 'h4C);
      for (int n = 2; n <= NREG; n++) begin
         drive(0, 0, 0, 0);
         step();
         check("halted_timing", bus.halted, (n == NREG));
      end
      for (int i = 0; i < 20; i++) begin
         drive($urandom % 2, $urandom % 2, 4 * ($urandom % 128), $urandom % 2);
         step();
         check("halted_hold", bus.halted, 1);
         check("halted_pc", bus.pc, 'h4C);
      end

      // Halt in reg 0 with a same-cycle redirect: halt is flushed.
      apply_reset();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0); step(); end
      halt_armed = 1'b1;
      halt_pc    = 12;
      drive(0, 0, 0, 0);
      step();
      drive(0, 1, 'h100, 0);
      check("hr_halt_dec", bus.halt_dec, 1);
      step();
      check("hr_state", bus.state, 0);
      check("hr_pc", bus.pc, 'h100);
      halt_armed = 1'b0;
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0); step(); end

      // Reset in the middle of a drain.
      halt_armed = 1'b1;
      halt_pc    = m_pc;
      drive(0, 0, 0, 0); step();
      drive(0, 0, 0, 0); step();
      check("mid_drain_state", bus.state, 1);
      drive(0, 0, 0, 0); step();
      apply_reset();

      // Randomized phase.
      halted_age = 0;
      armed_age  = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (!halt_armed && (m_state == 0) && (($urandom % 60) == 0)) begin
            halt_armed = 1'b1;
            halt_pc    = m_pc;
            armed_age  = 0;
         end
         if (halt_armed && (m_state == 0) && (++armed_age > 100)) halt_armed = 1'b0;
         halted_age = (m_state == 2) ? halted_age + 1 : 0;
         if ((halted_age > 20) || (($urandom % 700) == 0)) begin
            apply_reset();
            halted_age = 0;
         end
         drive(($urandom % 8) == 0, ($urandom % 12) == 0, 4 * ($urandom % 128),
               ($urandom % 10) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
